// File: rtl/time_keeper_if.sv
// Time-of-day bus: control inputs, preset value and the registered time/pulse outputs.
// The slave side is the time_keeper itself; the master side drives it.
interface time_keeper_if;
    logic [1:0]  mode;
    logic        run;
    logic        hourkey;
    logic        minkey;
    logic        seckey;
    logic        load;
    logic [17:0] load_val;
    logic [17:0] cur_clock;
    logic        sec_tick;
    logic        hour_chime;
    logic        load_err;

    modport master (
        output mode, run, hourkey, minkey, seckey, load, load_val,
        input  cur_clock, sec_tick, hour_chime, load_err
    );

    modport slave (
        input  mode, run, hourkey, minkey, seckey, load, load_val,
        output cur_clock, sec_tick, hour_chime, load_err
    );
endinterface

// File: rtl/time_keeper.sv
// 24 h time-of-day counter: prescaled 1 s tick, set-mode key increments,
// one-cycle preset load with range check, and registered tick/chime pulses.
module time_keeper #(
    parameter int TICK_DIV = 1000
) (
    input  logic          clk,
    input  logic          rst,
    time_keeper_if.slave  bus
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Wrapping increment; anything at or above the limit folds back to zero.
    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] last);
        if (val >= last) begin
            return 6'd0;
        end else begin
            return val + 6'd1;
        end
    endfunction

    logic [PRE_W-1:0] pre_r;
    logic [5:0]       hour_r;
    logic [5:0]       min_r;
    logic [5:0]       sec_r;
    logic             sec_tick_r;
    logic             hour_chime_r;
    logic             load_err_r;

    logic             set_mode_s;
    logic             counting_s;
    logic             tick_s;
    logic             load_ok_s;
    logic             sec_wrap_s;
    logic             min_wrap_s;
    logic [5:0]       carry_sec_s;
    logic [5:0]       carry_min_s;
    logic [5:0]       carry_hour_s;
    logic [5:0]       key_min_s;
    logic [5:0]       key_hour_s;

    // Mode decode, tick detect, load validation and the carry-chain next values.
    always_comb begin
        set_mode_s   = (bus.mode == 2'b01);
        counting_s   = !set_mode_s && bus.run;
        tick_s       = counting_s && (pre_r == PRE_LAST);
        load_ok_s    = (bus.load_val[17:12] <= 6'd23) &&
                       (bus.load_val[11:6]  <= 6'd59) &&
                       (bus.load_val[5:0]   <= 6'd59);
        sec_wrap_s   = (sec_r == 6'd59);
        min_wrap_s   = (min_r == 6'd59);
        // Full carry chain shared by the tick and the seconds key.
        carry_sec_s  = wrap_inc(sec_r, 6'd59);
        carry_min_s  = sec_wrap_s ? wrap_inc(min_r, 6'd59) : min_r;
        carry_hour_s = (sec_wrap_s && min_wrap_s) ? wrap_inc(hour_r, 6'd23) : hour_r;
        // Minute key carries into the hour but leaves seconds alone.
        key_min_s    = wrap_inc(min_r, 6'd59);
        key_hour_s   = min_wrap_s ? wrap_inc(hour_r, 6'd23) : hour_r;
    end

    // Time, prescaler and pulse registers with rst > load > keys > tick priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r        <= PRE_W'(0);
            hour_r       <= 6'd0;
            min_r        <= 6'd0;
            sec_r        <= 6'd0;
            sec_tick_r   <= 1'b0;
            hour_chime_r <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            sec_tick_r   <= 1'b0;
            hour_chime_r <= 1'b0;
            load_err_r   <= bus.load && !load_ok_s;
            if (bus.load && load_ok_s) begin
                hour_r <= bus.load_val[17:12];
                min_r  <= bus.load_val[11:6];
                sec_r  <= bus.load_val[5:0];
                pre_r  <= PRE_W'(0);
            end else if (set_mode_s) begin
                // Holding pre at zero makes the first tick after set mode a full period away.
                pre_r <= PRE_W'(0);
                if (bus.seckey) begin
                    sec_r  <= carry_sec_s;
                    min_r  <= carry_min_s;
                    hour_r <= carry_hour_s;
                end else if (bus.minkey) begin
                    min_r  <= key_min_s;
                    hour_r <= key_hour_s;
                end else if (bus.hourkey) begin
                    hour_r <= wrap_inc(hour_r, 6'd23);
                end else begin
                    hour_r <= hour_r;
                end
            end else if (tick_s) begin
                pre_r        <= PRE_W'(0);
                sec_r        <= carry_sec_s;
                min_r        <= carry_min_s;
                hour_r       <= carry_hour_s;
                sec_tick_r   <= 1'b1;
                hour_chime_r <= sec_wrap_s && min_wrap_s;
            end else if (counting_s) begin
                pre_r <= pre_r + PRE_W'(1);
            end else begin
                pre_r <= pre_r;
            end
        end
    end

    assign bus.cur_clock  = {hour_r, min_r, sec_r};
    assign bus.sec_tick   = sec_tick_r;
    assign bus.hour_chime = hour_chime_r;
    assign bus.load_err   = load_err_r;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV = 4; each task checks one behaviour.
module tb_time_keeper;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    time_keeper_if bus();

    time_keeper #(.TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] hms(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode = 2'b00;
        bus.run = 1'b1;
        repeat (2) step();
        checks++;
        if (bus.cur_clock !== 18'd0) begin
            errors++;
            $display("FAIL reset_time: got %h expected %h", bus.cur_clock, 18'd0);
        end
        checks++;
        if ({bus.sec_tick, bus.hour_chime, bus.load_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000",
                     {bus.sec_tick, bus.hour_chime, bus.load_err});
        end
    endtask

    task automatic test_count();
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (bus.sec_tick !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL count_tick cyc %0d: got %b expected %b", i, bus.sec_tick, (i % 4 == 0));
            end
            if (i == 4) begin
                checks++;
                if (bus.cur_clock !== hms(0, 0, 1)) begin
                    errors++;
                    $display("FAIL count_first: got %h expected %h", bus.cur_clock, hms(0, 0, 1));
                end
            end
            if (i == 12) begin
                checks++;
                if (bus.cur_clock !== hms(0, 0, 3)) begin
                    errors++;
                    $display("FAIL count_third: got %h expected %h", bus.cur_clock, hms(0, 0, 3));
                end
            end
        end
    endtask

    task automatic test_rollover();
        int chimes;
        chimes = 0;
        bus.run = 1'b0;
        bus.load = 1'b1;
        bus.load_val = hms(23, 59, 58);
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.cur_clock !== hms(23, 59, 58) || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL roll_load: got %h err %b expected %h err 0",
                     bus.cur_clock, bus.load_err, hms(23, 59, 58));
        end
        bus.run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (bus.hour_chime === 1'b1) chimes++;
            if (i == 4) begin
                checks++;
                if (bus.cur_clock !== hms(23, 59, 59) || bus.sec_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL roll_59: got %h tick %b expected %h tick 1",
                             bus.cur_clock, bus.sec_tick, hms(23, 59, 59));
                end
            end
            if (i == 8) begin
                checks++;
                if (bus.cur_clock !== 18'd0 || bus.hour_chime !== 1'b1) begin
                    errors++;
                    $display("FAIL roll_midnight: got %h chime %b expected 0 chime 1",
                             bus.cur_clock, bus.hour_chime);
                end
            end
        end
        checks++;
        if (chimes != 1) begin
            errors++;
            $display("FAIL roll_chime_count: got %0d expected 1", chimes);
        end
        bus.run = 1'b0;
    endtask

    task automatic test_load_err();
        logic [17:0] bad [2];
        bad[0] = hms(24, 0, 0);
        bad[1] = hms(10, 60, 0);
        for (int k = 0; k < 2; k++) begin
            bus.load = 1'b1;
            bus.load_val = bad[k];
            step();
            bus.load = 1'b0;
            checks++;
            if (bus.load_err !== 1'b1 || bus.cur_clock !== 18'd0) begin
                errors++;
                $display("FAIL load_err_%0d: got err %b time %h expected err 1 time 0",
                         k, bus.load_err, bus.cur_clock);
            end
            step();
            checks++;
            if (bus.load_err !== 1'b0) begin
                errors++;
                $display("FAIL load_err_len_%0d: got %b expected 0", k, bus.load_err);
            end
        end
        // pre was left at 1, so the next tick is three edges away.
        bus.run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (bus.sec_tick !== (i == 3)) begin
                errors++;
                $display("FAIL load_err_pre cyc %0d: got %b expected %b", i, bus.sec_tick, (i == 3));
            end
        end
        checks++;
        if (bus.cur_clock !== hms(0, 0, 1)) begin
            errors++;
            $display("FAIL load_err_resume: got %h expected %h", bus.cur_clock, hms(0, 0, 1));
        end
    endtask

    task automatic test_load_vs_tick();
        repeat (3) step();
        bus.load = 1'b1;
        bus.load_val = hms(12, 34, 56);
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.cur_clock !== hms(12, 34, 56) || bus.sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL load_tick: got %h tick %b expected %h tick 0",
                     bus.cur_clock, bus.sec_tick, hms(12, 34, 56));
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.sec_tick !== (i == 4)) begin
                errors++;
                $display("FAIL load_tick_pre cyc %0d: got %b expected %b", i, bus.sec_tick, (i == 4));
            end
        end
        checks++;
        if (bus.cur_clock !== hms(12, 34, 57)) begin
            errors++;
            $display("FAIL load_tick_next: got %h expected %h", bus.cur_clock, hms(12, 34, 57));
        end
    endtask

    task automatic test_set_mode();
        int pulses;
        pulses = 0;
        bus.run = 1'b0;
        bus.load = 1'b1;
        bus.load_val = hms(0, 59, 59);
        step();
        bus.load = 1'b0;
        bus.mode = 2'b01;
        bus.run = 1'b1;
        bus.seckey = 1'b1;
        step();
        bus.seckey = 1'b0;
        checks++;
        if (bus.cur_clock !== hms(1, 0, 0) || bus.sec_tick !== 1'b0 || bus.hour_chime !== 1'b0) begin
            errors++;
            $display("FAIL set_seckey: got %h tick %b chime %b expected %h 0 0",
                     bus.cur_clock, bus.sec_tick, bus.hour_chime, hms(1, 0, 0));
        end
        repeat (20) begin
            step();
            if (bus.sec_tick === 1'b1 || bus.hour_chime === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.cur_clock !== hms(1, 0, 0)) begin
            errors++;
            $display("FAIL set_quiet: got %0d pulses time %h expected 0 pulses %h",
                     pulses, bus.cur_clock, hms(1, 0, 0));
        end
        bus.mode = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.sec_tick !== (i == 4)) begin
                errors++;
                $display("FAIL set_exit cyc %0d: got %b expected %b", i, bus.sec_tick, (i == 4));
            end
        end
        checks++;
        if (bus.cur_clock !== hms(1, 0, 1)) begin
            errors++;
            $display("FAIL set_exit_time: got %h expected %h", bus.cur_clock, hms(1, 0, 1));
        end
    endtask

    task automatic test_keys();
        logic [17:0] start_v [4];
        logic [2:0]  keys_v  [4];
        logic [17:0] exp_v   [4];
        // keys_v is {seckey, minkey, hourkey}
        start_v[0] = hms(5, 10, 0);   keys_v[0] = 3'b011; exp_v[0] = hms(5, 11, 0);
        start_v[1] = hms(23, 45, 30); keys_v[1] = 3'b001; exp_v[1] = hms(0, 45, 30);
        start_v[2] = hms(7, 59, 10);  keys_v[2] = 3'b010; exp_v[2] = hms(8, 0, 10);
        start_v[3] = hms(8, 0, 10);   keys_v[3] = 3'b110; exp_v[3] = hms(8, 0, 11);
        bus.mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            bus.load = 1'b1;
            bus.load_val = start_v[k];
            step();
            bus.load = 1'b0;
            {bus.seckey, bus.minkey, bus.hourkey} = keys_v[k];
            step();
            {bus.seckey, bus.minkey, bus.hourkey} = 3'b000;
            checks++;
            if (bus.cur_clock !== exp_v[k]) begin
                errors++;
                $display("FAIL keys_%0d: got %h expected %h", k, bus.cur_clock, exp_v[k]);
            end
        end
        bus.mode = 2'b00;
        bus.run = 1'b0;
        {bus.seckey, bus.minkey, bus.hourkey} = 3'b111;
        step();
        {bus.seckey, bus.minkey, bus.hourkey} = 3'b000;
        step();
        checks++;
        if (bus.cur_clock !== hms(8, 0, 11)) begin
            errors++;
            $display("FAIL keys_ignored: got %h expected %h", bus.cur_clock, hms(8, 0, 11));
        end
    endtask

    task automatic test_reset_priority();
        bus.run = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        bus.load = 1'b1;
        bus.load_val = hms(12, 0, 0);
        step();
        checks++;
        if (bus.cur_clock !== 18'd0 || {bus.sec_tick, bus.hour_chime, bus.load_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_prio: got %h pulses %b expected 0 pulses 000",
                     bus.cur_clock, {bus.sec_tick, bus.hour_chime, bus.load_err});
        end
        bus.load_val = hms(30, 0, 0);
        step();
        checks++;
        if (bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_load_err: got %b expected 0", bus.load_err);
        end
        rst = 1'b0;
        bus.load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.sec_tick !== (i == 4)) begin
                errors++;
                $display("FAIL rst_restart cyc %0d: got %b expected %b", i, bus.sec_tick, (i == 4));
            end
        end
        checks++;
        if (bus.cur_clock !== hms(0, 0, 1)) begin
            errors++;
            $display("FAIL rst_restart_time: got %h expected %h", bus.cur_clock, hms(0, 0, 1));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.mode = 2'b00;
        bus.run = 1'b0;
        bus.hourkey = 1'b0;
        bus.minkey = 1'b0;
        bus.seckey = 1'b0;
        bus.load = 1'b0;
        bus.load_val = 18'd0;
        test_reset();
        test_count();
        test_rollover();
        test_load_err();
        test_load_vs_tick();
        test_set_mode();
        test_keys();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
